ahb_arbiter: RTL and testbench

- Bus arbiter for the AHB matrix. It shares one AHB layer between up to 16 masters.
- Takes per-master HBUSREQ/HLOCK and generates one-hot HGRANT plus the owner index HMASTER. HMASTER drives the master-to-slave address/control mux.
- Sees the muxed HTRANS/HBURST of the current owner and the HREADY/HRESP returned by the slave-to-master mux.
- Keeps fixed-length bursts and locked sequences unbroken.

---
 rtl/ahb_arbiter.sv | 152 +++++++++++++++
 tb/tb_ahb_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: fixed-priority or round-robin grant for up to 16 masters,
// holding the grant across fixed-length bursts and locked sequences.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int DEFAULT_MASTER = 0,
  parameter int ARB_MODE       = 1
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [3:0]             HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] ST_ARB    = 2'd0;
  localparam logic [1:0] ST_BURST  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [3:0]             DEF_IDX   = 4'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] grantQ, grantD;
  logic [3:0]             masterQ, masterD;
  logic                   mastLockQ, mastLockD;
  logic [4:0]             beatsQ, beatsD;
  logic [1:0]             stateQ, stateD;
  logic [3:0]             rrPtrQ, rrPtrD;

  logic [3:0]             grantIdx;
  logic [4:0]             beatsUpd;
  logic [3:0]             arbIdx;
  logic [NUM_MASTERS-1:0] arbGrant;
  logic                   curLock;
  logic                   holdBurst;
  logic                   relArb;

  always_comb begin
    grantIdx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (grantQ[i]) grantIdx = 4'(i);
  end

  // Beats remaining after the transfer accepted at this edge.
  always_comb begin
    beatsUpd = beatsQ;
    case (HTRANS)
      TR_NONSEQ: begin
        case (HBURST)
          3'b010, 3'b011: beatsUpd = 5'd3;
          3'b100, 3'b101: beatsUpd = 5'd7;
          3'b110, 3'b111: beatsUpd = 5'd15;
          default:        beatsUpd = 5'd0;
        endcase
      end
      TR_SEQ:  beatsUpd = (beatsQ == 5'd0) ? 5'd0 : beatsQ - 5'd1;
      TR_IDLE: beatsUpd = 5'd0;
      default: beatsUpd = beatsQ;
    endcase
  end

  // Loops run backwards so the first candidate in search order is the last assignment.
  always_comb begin
    arbIdx = DEF_IDX;
    if (ARB_MODE == 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--)
        if (HBUSREQ[i]) arbIdx = 4'(i);
    end else begin
      for (int k = NUM_MASTERS; k >= 1; k--)
        if (HBUSREQ[(int'(rrPtrQ) + k) % NUM_MASTERS])
          arbIdx = 4'((int'(rrPtrQ) + k) % NUM_MASTERS);
    end
    for (int i = 0; i < NUM_MASTERS; i++)
      arbGrant[i] = (4'(i) == arbIdx);
  end

  always_comb begin
    grantD    = grantQ;
    masterD   = masterQ;
    mastLockD = mastLockQ;
    beatsD    = beatsQ;
    stateD    = stateQ;
    rrPtrD    = rrPtrQ;
    curLock   = |(HLOCK & grantQ);
    holdBurst = (beatsUpd >= 5'd2);
    relArb    = 1'b0;
    if (HREADY) begin
      masterD   = grantIdx;
      mastLockD = curLock;
      beatsD    = beatsUpd;
      // A held lock outranks burst release; a running burst outranks re-arbitration.
      case (stateQ)
        ST_BURST: begin
          if (holdBurst)    stateD = ST_BURST;
          else if (curLock) stateD = ST_LOCKED;
          else              relArb = 1'b1;
        end
        ST_LOCKED: begin
          if (curLock)        stateD = ST_LOCKED;
          else if (holdBurst) stateD = ST_BURST;
          else                relArb = 1'b1;
        end
        default: begin
          if (holdBurst) stateD = curLock ? ST_LOCKED : ST_BURST;
          else           relArb = 1'b1;
        end
      endcase
      if (relArb) begin
        grantD = arbGrant;
        if (arbGrant != grantQ) rrPtrD = arbIdx;
        stateD = (|(HLOCK & arbGrant)) ? ST_LOCKED : ST_ARB;
      end
    end else if (HRESP != RESP_OKAY) begin
      beatsD = 5'd0;
      stateD = ST_ARB;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grantQ    <= DEF_GRANT;
      masterQ   <= DEF_IDX;
      mastLockQ <= 1'b0;
      beatsQ    <= 5'd0;
      stateQ    <= ST_ARB;
      rrPtrQ    <= DEF_IDX;
    end else begin
      grantQ    <= grantD;
      masterQ   <= masterD;
      mastLockQ <= mastLockD;
      beatsQ    <= beatsD;
      stateQ    <= stateD;
      rrPtrQ    <= rrPtrD;
    end
  end

  assign HGRANT    = grantQ;
  assign HMASTER   = masterQ;
  assign HMASTLOCK = mastLockQ;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed, table-driven bench for ahb_arbiter (3 masters, round-robin, default master 0).
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NS = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101;
  localparam logic [1:0] OKAY = 2'b00, RETRY = 2'b10;

  typedef struct {
    bit         rst;
    logic [2:0] req;
    logic [2:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [1:0] resp;
    logic [2:0] expGrant;
    logic [3:0] expMaster;
    logic       expMlock;
    string      tag;
  } vec_t;

  logic       HCLK;
  logic       HRESETn;
  logic [2:0] HBUSREQ;
  logic [2:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [1:0] HRESP;
  logic [2:0] HGRANT;
  logic [3:0] HMASTER;
  logic       HMASTLOCK;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  ahb_arbiter #(.NUM_MASTERS(3), .DEFAULT_MASTER(0), .ARB_MODE(1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
    .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic vec_t mk(bit rst, logic [2:0] req, logic [2:0] lock,
                              logic [1:0] trans, logic [2:0] burst, logic ready,
                              logic [1:0] resp, logic [2:0] eg, logic [3:0] em,
                              logic el, string tag);
    vec_t v;
    v.rst = rst; v.req = req; v.lock = lock; v.trans = trans; v.burst = burst;
    v.ready = ready; v.resp = resp; v.expGrant = eg; v.expMaster = em;
    v.expMlock = el; v.tag = tag;
    return v;
  endfunction

  task automatic checkOutput(input vec_t v);
    checks += 3;
    if (HGRANT !== v.expGrant) begin
      errors++;
      $display("[TB] FAIL %s.HGRANT: got %b expected %b", v.tag, HGRANT, v.expGrant);
    end
    if (HMASTER !== v.expMaster) begin
      errors++;
      $display("[TB] FAIL %s.HMASTER: got %0d expected %0d", v.tag, HMASTER, v.expMaster);
    end
    if (HMASTLOCK !== v.expMlock) begin
      errors++;
      $display("[TB] FAIL %s.HMASTLOCK: got %b expected %b", v.tag, HMASTLOCK, v.expMlock);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    HBUSREQ = v.req; HLOCK = v.lock; HTRANS = v.trans; HBURST = v.burst;
    HREADY = v.ready; HRESP = v.resp;
    @(posedge HCLK);
    #1;
    checkOutput(v);
  endtask

  task automatic doReset();
    HBUSREQ = '0; HLOCK = '0; HTRANS = IDLE; HBURST = SINGLE; HREADY = 1'b1; HRESP = OKAY;
    @(negedge HCLK);
    HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  initial begin
    HRESETn = 1'b1;

    // Round-robin between masters 1 and 2 with SINGLE transfers.
    vecs.push_back(mk(1, 3'b110, 3'b000, NS, SINGLE, 1, OKAY, 3'b010, 0, 0, "rr1"));
    vecs.push_back(mk(0, 3'b110, 3'b000, NS, SINGLE, 1, OKAY, 3'b100, 1, 0, "rr2"));
    vecs.push_back(mk(0, 3'b110, 3'b000, NS, SINGLE, 1, OKAY, 3'b010, 2, 0, "rr3"));
    vecs.push_back(mk(0, 3'b110, 3'b000, NS, SINGLE, 1, OKAY, 3'b100, 1, 0, "rr4"));
    // INCR4 from master 1, master 2 requesting from beat 1.
    vecs.push_back(mk(1, 3'b010, 3'b000, IDLE, SINGLE, 1, OKAY, 3'b010, 0, 0, "b4.g"));
    vecs.push_back(mk(0, 3'b010, 3'b000, IDLE, SINGLE, 1, OKAY, 3'b010, 1, 0, "b4.own"));
    vecs.push_back(mk(0, 3'b110, 3'b000, NS,   INCR4,  1, OKAY, 3'b010, 1, 0, "b4.beat1"));
    vecs.push_back(mk(0, 3'b110, 3'b000, SEQ,  INCR4,  1, OKAY, 3'b010, 1, 0, "b4.beat2"));
    vecs.push_back(mk(0, 3'b110, 3'b000, SEQ,  INCR4,  1, OKAY, 3'b100, 1, 0, "b4.beat3"));
    vecs.push_back(mk(0, 3'b100, 3'b000, SEQ,  INCR4,  1, OKAY, 3'b100, 2, 0, "b4.beat4"));
    vecs.push_back(mk(0, 3'b100, 3'b000, IDLE, SINGLE, 1, OKAY, 3'b100, 2, 0, "b4.after"));
    // Same INCR4 with a two-cycle stall on beat 2 and one BUSY.
    vecs.push_back(mk(1, 3'b010, 3'b000, IDLE, SINGLE, 1, OKAY, 3'b010, 0, 0, "st.g"));
    vecs.push_back(mk(0, 3'b010, 3'b000, IDLE, SINGLE, 1, OKAY, 3'b010, 1, 0, "st.own"));
    vecs.push_back(mk(0, 3'b110, 3'b000, NS,   INCR4,  1, OKAY, 3'b010, 1, 0, "st.beat1"));
    vecs.push_back(mk(0, 3'b110, 3'b000, SEQ,  INCR4,  0, OKAY, 3'b010, 1, 0, "st.wait1"));
    vecs.push_back(mk(0, 3'b110, 3'b000, SEQ,  INCR4,  0, OKAY, 3'b010, 1, 0, "st.wait2"));
    vecs.push_back(mk(0, 3'b110, 3'b000, SEQ,  INCR4,  1, OKAY, 3'b010, 1, 0, "st.beat2"));
    vecs.push_back(mk(0, 3'b110, 3'b000, BUSY, INCR4,  1, OKAY, 3'b010, 1, 0, "st.busy"));
    vecs.push_back(mk(0, 3'b110, 3'b000, SEQ,  INCR4,  1, OKAY, 3'b100, 1, 0, "st.beat3"));
    vecs.push_back(mk(0, 3'b100, 3'b000, SEQ,  INCR4,  1, OKAY, 3'b100, 2, 0, "st.beat4"));
    // Locked sequence of three SINGLEs from master 2 while master 0 requests.
    vecs.push_back(mk(1, 3'b101, 3'b100, IDLE, SINGLE, 1, OKAY, 3'b100, 0, 0, "lk.g"));
    vecs.push_back(mk(0, 3'b101, 3'b100, IDLE, SINGLE, 1, OKAY, 3'b100, 2, 1, "lk.own"));
    vecs.push_back(mk(0, 3'b101, 3'b100, NS,   SINGLE, 1, OKAY, 3'b100, 2, 1, "lk.s1"));
    vecs.push_back(mk(0, 3'b101, 3'b100, NS,   SINGLE, 1, OKAY, 3'b100, 2, 1, "lk.s2"));
    vecs.push_back(mk(0, 3'b001, 3'b000, NS,   SINGLE, 0, OKAY, 3'b100, 2, 1, "lk.stall"));
    vecs.push_back(mk(0, 3'b001, 3'b000, NS,   SINGLE, 1, OKAY, 3'b001, 2, 0, "lk.s3rel"));
    vecs.push_back(mk(0, 3'b001, 3'b000, IDLE, SINGLE, 1, OKAY, 3'b001, 0, 0, "lk.after"));
    // INCR8 from master 1 retried on beat 3; BUSY on the completion edge holds the counter.
    vecs.push_back(mk(1, 3'b010, 3'b000, IDLE, SINGLE, 1, OKAY,  3'b010, 0, 0, "rt.g"));
    vecs.push_back(mk(0, 3'b010, 3'b000, IDLE, SINGLE, 1, OKAY,  3'b010, 1, 0, "rt.own"));
    vecs.push_back(mk(0, 3'b110, 3'b000, NS,   INCR8,  1, OKAY,  3'b010, 1, 0, "rt.beat1"));
    vecs.push_back(mk(0, 3'b110, 3'b000, SEQ,  INCR8,  1, OKAY,  3'b010, 1, 0, "rt.beat2"));
    vecs.push_back(mk(0, 3'b110, 3'b000, SEQ,  INCR8,  1, OKAY,  3'b010, 1, 0, "rt.beat3"));
    vecs.push_back(mk(0, 3'b110, 3'b000, SEQ,  INCR8,  0, RETRY, 3'b010, 1, 0, "rt.resp1"));
    vecs.push_back(mk(0, 3'b110, 3'b000, BUSY, INCR8,  1, RETRY, 3'b100, 1, 0, "rt.resp2"));
    vecs.push_back(mk(0, 3'b100, 3'b000, IDLE, SINGLE, 1, OKAY,  3'b100, 2, 0, "rt.after"));

    // Reset state, held for 10 idle cycles.
    doReset();
    #1;
    checkOutput(mk(0, 3'b000, 3'b000, IDLE, SINGLE, 1, OKAY, 3'b001, 0, 0, "rst"));
    for (int i = 0; i < 10; i++)
      applyStimulus(mk(0, 3'b000, 3'b000, IDLE, SINGLE, 1, OKAY, 3'b001, 0, 0, "rst.hold"));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) doReset();
      applyStimulus(vecs[i]);
    end

    // Asynchronous reset in the middle of a burst, then confirm no burst state survived.
    doReset();
    applyStimulus(mk(0, 3'b010, 3'b000, IDLE, SINGLE, 1, OKAY, 3'b010, 0, 0, "mr.g"));
    applyStimulus(mk(0, 3'b010, 3'b000, IDLE, SINGLE, 1, OKAY, 3'b010, 1, 0, "mr.own"));
    applyStimulus(mk(0, 3'b110, 3'b000, NS,   INCR8,  1, OKAY, 3'b010, 1, 0, "mr.beat1"));
    #2;
    HRESETn = 1'b0;
    #1;
    checkOutput(mk(0, 3'b000, 3'b000, IDLE, SINGLE, 1, OKAY, 3'b001, 0, 0, "mr.inrst"));
    @(negedge HCLK);
    HRESETn = 1'b1;
    applyStimulus(mk(0, 3'b110, 3'b000, BUSY, INCR8, 1, OKAY, 3'b010, 0, 0, "mr.post"));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
